// File: rtl/kitchen_pkg.sv
// Shared kitchen playfield definitions: pot state encoding, key/tile/item codes
// and small arithmetic helpers used by the pot, plate and onion stages.
package kitchen_pkg;

    typedef enum logic [1:0] {
        POT_EMPTY   = 2'd0,
        POT_READY   = 2'd1,
        POT_COOKING = 2'd2,
        POT_BURNT   = 2'd3
    } pot_state_t;

    localparam logic [7:0] KEY_E      = 8'h08;
    localparam logic [3:0] TILE_STOVE = 4'd3;

    localparam logic [2:0] ITEM_NONE  = 3'd0;
    localparam logic [2:0] ITEM_ONION = 3'd1;
    localparam logic [2:0] ITEM_PLATE = 3'd2;

    localparam int TIMER_W = 10;

    // Increment that sticks at the top of a 4-bit bar.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        if (v == 4'd15) begin
            sat_inc4 = 4'd15;
        end else begin
            sat_inc4 = v + 4'd1;
        end
    endfunction

endpackage

// File: rtl/pot_cooker_if.sv
// Playfield-to-pot signal bundle. The playfield (master) drives the penguin's
// key, position and held item; the pot (slave) publishes its status.
interface pot_cooker_if;
    logic [7:0] keycode;
    logic       wallFlag;
    logic [3:0] tileType;
    logic [2:0] spriteIndexIn;
    logic [1:0] potState;
    logic [1:0] onionCount;
    logic [3:0] cookProgress;
    logic       onionConsumed;
    logic       burnWarning;

    modport master (
        output keycode, wallFlag, tileType, spriteIndexIn,
        input  potState, onionCount, cookProgress, onionConsumed, burnWarning
    );

    modport slave (
        input  keycode, wallFlag, tileType, spriteIndexIn,
        output potState, onionCount, cookProgress, onionConsumed, burnWarning
    );
endinterface

// File: rtl/key_debounce.sv
// E-key debounce shared by the kitchen stages. The counter runs while E is
// released (wrapping at 16); a press is acted on only once enough released
// frames have accumulated, and acting on it clears the counter so a held key
// produces a single interact.
module key_debounce
    import kitchen_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] i_keycode,
    output logic       o_interact
);

    localparam logic [3:0] DB_MIN = 4'(DEBOUNCE);

    logic [3:0] r_counter;
    logic       w_is_e;

    assign w_is_e     = (i_keycode == KEY_E);
    assign o_interact = w_is_e && (r_counter >= DB_MIN);

    // Released frames count up, an accepted press clears, a premature press holds.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_counter <= 4'd0;
        end else if (!w_is_e) begin
            r_counter <= r_counter + 4'd1;
        end else if (o_interact) begin
            r_counter <= 4'd0;
        end else begin
            r_counter <= r_counter;
        end
    end

endmodule

// File: rtl/pot_cooker.sv
// Stove pot: accepts onions, cooks once full, holds ready soup for pickup and
// burns it if left too long. Every output is a register updated on the frame
// edge that samples the qualifying inputs.
module pot_cooker
    import kitchen_pkg::*;
#(
    parameter int ONIONS_NEEDED = 3,
    parameter int COOK_FRAMES   = 320,
    parameter int BURN_FRAMES   = 480,
    parameter int DEBOUNCE      = 3
) (
    input  logic         frame_clk,
    input  logic         Reset,
    pot_cooker_if.slave  bus
);

    localparam logic [1:0]         ONIONS_FULL = 2'(ONIONS_NEEDED);
    localparam logic [TIMER_W-1:0] COOK_LAST   = TIMER_W'(COOK_FRAMES - 1);
    localparam logic [TIMER_W-1:0] BURN_LAST   = TIMER_W'(BURN_FRAMES - 1);
    localparam logic [TIMER_W-1:0] WARN_AT     = TIMER_W'(BURN_FRAMES / 2);
    // Frames per progress-bar step, minus one (COOK_FRAMES is a multiple of 16).
    localparam logic [5:0]         STEP_LAST   = 6'(COOK_FRAMES / 16 - 1);

    pot_state_t         r_state;
    logic [1:0]         r_count;
    logic [TIMER_W-1:0] r_timer;
    logic [5:0]         r_step;
    logic [3:0]         r_prog;
    logic               r_consumed;
    logic               r_warn;

    pot_state_t         w_state_nxt;
    logic [1:0]         w_count_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic [5:0]         w_step_nxt;
    logic [3:0]         w_prog_nxt;
    logic               w_consumed_nxt;
    logic               w_warn_nxt;

    logic               w_interact;
    logic               w_take;
    logic [1:0]         w_count_inc;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .i_keycode  (bus.keycode),
        .o_interact (w_interact)
    );

    // An interact only reaches the pot when the penguin faces the stove.
    assign w_take      = w_interact && bus.wallFlag && (bus.tileType == TILE_STOVE);
    assign w_count_inc = r_count + 2'd1;

    // Pot state register and all registered outputs.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= POT_EMPTY;
            r_count    <= 2'd0;
            r_timer    <= '0;
            r_step     <= 6'd0;
            r_prog     <= 4'd0;
            r_consumed <= 1'b0;
            r_warn     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_timer    <= w_timer_nxt;
            r_step     <= w_step_nxt;
            r_prog     <= w_prog_nxt;
            r_consumed <= w_consumed_nxt;
            r_warn     <= w_warn_nxt;
        end
    end

    // Next-state and next-output decode; holds everything unless a transition fires.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_timer_nxt    = r_timer;
        w_step_nxt     = r_step;
        w_prog_nxt     = r_prog;
        w_consumed_nxt = 1'b0;

        case (r_state)
            POT_EMPTY: begin
                if (w_take && (bus.spriteIndexIn == ITEM_ONION) && (r_count < ONIONS_FULL)) begin
                    w_count_nxt    = w_count_inc;
                    w_consumed_nxt = 1'b1;
                    if (w_count_inc == ONIONS_FULL) begin
                        // Cooking starts on the same edge the last onion goes in.
                        w_state_nxt = POT_COOKING;
                        w_timer_nxt = '0;
                        w_step_nxt  = 6'd0;
                        w_prog_nxt  = 4'd0;
                    end else begin
                        w_state_nxt = POT_EMPTY;
                    end
                end else begin
                    w_state_nxt = POT_EMPTY;
                end
            end

            POT_COOKING: begin
                if (r_step == STEP_LAST) begin
                    w_step_nxt = 6'd0;
                    w_prog_nxt = sat_inc4(r_prog);
                end else begin
                    w_step_nxt = r_step + 6'd1;
                    w_prog_nxt = r_prog;
                end
                if (r_timer == COOK_LAST) begin
                    w_state_nxt = POT_READY;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end

            POT_READY: begin
                // Pickup wins over the burn on the expiry frame.
                if (w_take && (bus.spriteIndexIn == ITEM_PLATE)) begin
                    w_state_nxt = POT_EMPTY;
                    w_count_nxt = 2'd0;
                    w_timer_nxt = '0;
                    w_step_nxt  = 6'd0;
                    w_prog_nxt  = 4'd0;
                end else if (r_timer == BURN_LAST) begin
                    w_state_nxt = POT_BURNT;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end

            POT_BURNT: begin
                // Only an empty hand can dump a burnt pot.
                if (w_take && (bus.spriteIndexIn == ITEM_NONE)) begin
                    w_state_nxt = POT_EMPTY;
                    w_count_nxt = 2'd0;
                    w_timer_nxt = '0;
                    w_step_nxt  = 6'd0;
                    w_prog_nxt  = 4'd0;
                end else begin
                    w_state_nxt = POT_BURNT;
                end
            end

            default: begin
                w_state_nxt = POT_EMPTY;
                w_count_nxt = 2'd0;
                w_timer_nxt = '0;
                w_step_nxt  = 6'd0;
                w_prog_nxt  = 4'd0;
            end
        endcase

        w_warn_nxt = (w_state_nxt == POT_READY) && (w_timer_nxt >= WARN_AT);
    end

    assign bus.potState      = r_state;
    assign bus.onionCount    = r_count;
    assign bus.cookProgress  = r_prog;
    assign bus.onionConsumed = r_consumed;
    assign bus.burnWarning   = r_warn;

endmodule

// File: tb/tb_pot_cooker.sv
// Directed bench for pot_cooker: a vector table covers debounce and filling,
// hand-written sequences cover cooking, pickup, burning and reset.
module tb_pot_cooker;

    localparam logic [7:0] NK = 8'h00;
    localparam logic [7:0] EK = 8'h08;

    logic frame_clk = 1'b0;
    logic Reset;

    pot_cooker_if bus();

    pot_cooker #(
        .ONIONS_NEEDED (3),
        .COOK_FRAMES   (320),
        .BURN_FRAMES   (480),
        .DEBOUNCE      (3)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] key;
        logic       wall;
        logic [3:0] tile;
        logic [2:0] item;
        logic [1:0] st;
        logic [1:0] cnt;
        logic [3:0] prog;
        logic       cons;
        logic       warn;
    } vec_t;

    vec_t tbl [32];

    task automatic drive(input logic [7:0] k, input logic w, input logic [3:0] t, input logic [2:0] it);
        bus.keycode       = k;
        bus.wallFlag      = w;
        bus.tileType      = t;
        bus.spriteIndexIn = it;
    endtask

    task automatic tick;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [1:0] st, input logic [1:0] cnt,
                              input logic [3:0] pr, input logic co, input logic wa);
        n_vec++;
        if ({bus.potState, bus.onionCount, bus.cookProgress, bus.onionConsumed, bus.burnWarning}
            !== {st, cnt, pr, co, wa}) begin
            n_bad++;
            $display("FAIL %s: got state=%0d count=%0d prog=%0d cons=%0b warn=%0b, want state=%0d count=%0d prog=%0d cons=%0b warn=%0b",
                     name, bus.potState, bus.onionCount, bus.cookProgress, bus.onionConsumed,
                     bus.burnWarning, st, cnt, pr, co, wa);
        end
    endtask

    // Three onions from a cleared debounce counter; the third starts cooking.
    task automatic fill3(input string name);
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 3; r++) begin
                drive(NK, 1'b1, 4'd3, 3'd1);
                tick();
            end
            drive(EK, 1'b1, 4'd3, 3'd1);
            tick();
            expect_out(name, (i == 2) ? 2'd2 : 2'd0, 2'(i + 1), 4'd0, 1'b1, 1'b0);
        end
    endtask

    // Full cook with the key released; checks the last COOKING frame and READY entry.
    task automatic cook_all(input string name);
        for (int k = 1; k <= 320; k++) begin
            drive(NK, 1'b1, 4'd3, 3'd0);
            tick();
            if (k == 319) expect_out(name, 2'd2, 2'd3, 4'd15, 1'b0, 1'b0);
            if (k == 320) expect_out(name, 2'd1, 2'd3, 4'd15, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Debounce and filling: {key, wall, tile, item} -> {state, count, prog, cons, warn}
        tbl[0]  = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{EK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0};
        tbl[3]  = '{EK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0};
        tbl[4]  = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0};
        tbl[5]  = '{EK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b1, 1'b0};
        tbl[6]  = '{EK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[7]  = '{EK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[8]  = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[9]  = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[10] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[11] = '{EK, 1'b0, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[12] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[13] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[14] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[15] = '{EK, 1'b1, 4'd1, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[16] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[17] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[18] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[19] = '{EK, 1'b1, 4'd3, 3'd2, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[20] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[21] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[22] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0};
        tbl[23] = '{EK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd2, 4'd0, 1'b1, 1'b0};
        tbl[24] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0};
        tbl[25] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0};
        tbl[26] = '{NK, 1'b1, 4'd3, 3'd1, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0};
        tbl[27] = '{EK, 1'b1, 4'd3, 3'd1, 2'd2, 2'd3, 4'd0, 1'b1, 1'b0};
        tbl[28] = '{NK, 1'b1, 4'd3, 3'd1, 2'd2, 2'd3, 4'd0, 1'b0, 1'b0};
        tbl[29] = '{NK, 1'b1, 4'd3, 3'd1, 2'd2, 2'd3, 4'd0, 1'b0, 1'b0};
        tbl[30] = '{NK, 1'b1, 4'd3, 3'd1, 2'd2, 2'd3, 4'd0, 1'b0, 1'b0};
        tbl[31] = '{EK, 1'b1, 4'd3, 3'd1, 2'd2, 2'd3, 4'd0, 1'b0, 1'b0};

        // Reset
        Reset = 1'b1;
        drive(NK, 1'b1, 4'd3, 3'd1);
        tick();
        tick();
        expect_out("reset", 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        Reset = 1'b0;

        // Table: debounce, off-tile, fill to COOKING, onion while cooking
        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].key, tbl[i].wall, tbl[i].tile, tbl[i].item);
            tick();
            expect_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].cnt, tbl[i].prog,
                       tbl[i].cons, tbl[i].warn);
        end

        // Remainder of the cook: timer is 4 after vec31, bar steps every 20 frames
        for (int k = 5; k <= 320; k++) begin
            drive(NK, 1'b1, 4'd3, 3'd0);
            tick();
            if (k < 320) expect_out("cooking", 2'd2, 2'd3, 4'(k / 20), 1'b0, 1'b0);
            else         expect_out("ready", 2'd1, 2'd3, 4'd15, 1'b0, 1'b0);
        end

        // READY for 99 frames (debounce counter ends at 15), plate pickup on frame 100
        for (int j = 1; j <= 99; j++) begin
            drive(NK, 1'b1, 4'd3, 3'd2);
            tick();
            expect_out("ready_wait", 2'd1, 2'd3, 4'd15, 1'b0, 1'b0);
        end
        drive(EK, 1'b1, 4'd3, 3'd2);
        tick();
        expect_out("pickup", 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);

        // Burn: untouched READY pot
        fill3("fill2");
        cook_all("cook2");
        for (int j = 1; j <= 480; j++) begin
            drive(NK, 1'b1, 4'd3, 3'd0);
            tick();
            if (j == 239) expect_out("warn_before", 2'd1, 2'd3, 4'd15, 1'b0, 1'b0);
            if (j == 240) expect_out("warn_rise", 2'd1, 2'd3, 4'd15, 1'b0, 1'b1);
            if (j == 479) expect_out("warn_last", 2'd1, 2'd3, 4'd15, 1'b0, 1'b1);
            if (j == 480) expect_out("burnt", 2'd3, 2'd3, 4'd15, 1'b0, 1'b0);
        end
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < 3; r++) begin
                drive(NK, 1'b1, 4'd3, 3'd0);
                tick();
            end
            // plate, then onion, then empty hand
            drive(EK, 1'b1, 4'd3, (p == 0) ? 3'd2 : ((p == 1) ? 3'd1 : 3'd0));
            tick();
            if (p < 2) expect_out("burnt_ignore", 2'd3, 2'd3, 4'd15, 1'b0, 1'b0);
            else       expect_out("dump", 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        end

        // Pickup on the exact burn-expiry frame
        fill3("fill3");
        cook_all("cook3");
        for (int j = 1; j <= 479; j++) begin
            drive(NK, 1'b1, 4'd3, 3'd2);
            tick();
        end
        expect_out("pre_expiry", 2'd1, 2'd3, 4'd15, 1'b0, 1'b1);
        drive(EK, 1'b1, 4'd3, 3'd2);
        tick();
        expect_out("expiry_pickup", 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-cook
        fill3("fill4");
        for (int k = 1; k <= 150; k++) begin
            drive(NK, 1'b1, 4'd3, 3'd1);
            tick();
        end
        expect_out("cook150", 2'd2, 2'd3, 4'd7, 1'b0, 1'b0);
        #1;
        Reset = 1'b1;
        #1;
        expect_out("reset_async", 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        #1;
        Reset = 1'b0;
        for (int r = 0; r < 3; r++) begin
            drive(NK, 1'b1, 4'd3, 3'd1);
            tick();
        end
        drive(EK, 1'b1, 4'd3, 3'd1);
        tick();
        expect_out("after_reset", 2'd0, 2'd1, 4'd0, 1'b1, 1'b0);
        drive(NK, 1'b1, 4'd3, 3'd1);
        tick();
        expect_out("pulse_end", 2'd0, 2'd1, 4'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pot_cooker.md
# pot_cooker

Stove-side pot state machine for the kitchen playfield. It accepts onions from the penguin, cooks the soup once the pot is full, and publishes `potState` to the plate stage, which fills a held plate only when `potState == 1`. It also times out ready soup into a burnt pot. All state advances once per video frame on `frame_clk` (vsync). The pot sits directly upstream of the plate stage and shares its keypress debounce, so both blocks act on the same frame.

## Interface
Parameters:
- `ONIONS_NEEDED`, default 3: onions that fill the pot (range 1..3).
- `COOK_FRAMES`, default 320: frames from full to ready. Must be a multiple of 16.
- `BURN_FRAMES`, default 480: frames a ready pot waits before it burns.
- `DEBOUNCE`, default 3: minimum debounce count before an E press is acted on.

Ports:
- `frame_clk` in 1: the single clock (vsync).
- `Reset` in 1: asynchronous, active-high reset.
- `keycode` in 8: USB keycode. `8'h08` is E (interact).
- `wallFlag` in 1: penguin is touching a wall or counter.
- `tileType` in 4: tile the penguin is facing. 3 = stove.
- `spriteIndexIn` in 3: item the penguin holds. 0 = none, 1 = onion, 2 = plate.
- `potState` out 2: 0 EMPTY/FILLING, 1 READY, 2 COOKING, 3 BURNT.
- `onionCount` out 2: onions currently in the pot.
- `cookProgress` out 4: progress bar level, 0..15.
- `onionConsumed` out 1: one-frame pulse. The onion stage despawns the held onion on this pulse.
- `burnWarning` out 1: high during the second half of the READY window.

## Operation
**Debounce**
- 4-bit `counter`.
- When `keycode != 8'h08`, `counter` increments and wraps modulo 16.
- When `keycode == 8'h08` and `counter >= DEBOUNCE`, the frame is an *interact*, and `counter` clears to 0.
- When `keycode == 8'h08` and `counter < DEBOUNCE`, `counter` holds.
- An interact counts only when `wallFlag && tileType == 3`. Otherwise it is ignored, but the counter still clears.

**FSM**
- EMPTY/FILLING (0):
  - Interact with `spriteIndexIn == 1` and `onionCount < ONIONS_NEEDED`: `onionCount + 1`, pulse `onionConsumed`.
  - When the incremented count equals `ONIONS_NEEDED`, go to COOKING on that same edge, with the timer and `cookProgress` at 0.
- COOKING (2):
  - The timer counts frames.
  - `cookProgress` increments every `COOK_FRAMES/16` frames and saturates at 15.
  - At `COOK_FRAMES` the pot goes to READY, and the timer restarts at 0.
  - Interacts are ignored; onions are not consumed.
- READY (1):
  - The timer counts frames.
  - `burnWarning = (timer >= BURN_FRAMES/2)`.
  - Interact with `spriteIndexIn == 2`: go to EMPTY and clear `onionCount`, timer and `cookProgress`. The plate stage fills the plate on that same edge.
  - When the timer reaches `BURN_FRAMES`, go to BURNT.
- BURNT (3):
  - Interact with `spriteIndexIn == 0` dumps the pot: go to EMPTY and clear everything.
  - A plate or an onion interact is ignored.

**Boundaries**
- A pickup interact on the exact frame the burn timer expires is a pickup: the interact has priority.
- An onion interact while the pot is not in EMPTY/FILLING produces no pulse.

## Timing
- All outputs are registered. Each output changes on the `frame_clk` edge that samples the qualifying inputs.
- `onionConsumed` is high for exactly one frame.
- Reset values:
  - `potState = 0`, `onionCount = 0`, `cookProgress = 0`
  - `onionConsumed = 0`, `burnWarning = 0`
  - `counter = 0`, timer = 0
- Reset mid-cook or mid-ready returns the pot to EMPTY immediately (asynchronous). No pulse is emitted.
- The timer is 10 bits wide. `COOK_FRAMES` and `BURN_FRAMES` must each be ≤ 1023.
- Cook latency from the third onion to READY is exactly `COOK_FRAMES` frames.

## Structure
- Shared package `kitchen_pkg` holds:
  - the `pot_state_t` enum (0..3)
  - `KEY_E = 8'h08`
  - `TILE_STOVE = 3`
  - the `ITEM_NONE/ONION/PLATE` codes (0/1/2)
- The plate stage imports the same package.
- Sub-module `key_debounce` holds the debounce counter and produces the `interact` strobe. It is reusable by the plate and onion stages.

## Test plan
- **Fill and cook:** three debounced onion interacts at the stove → `onionConsumed` pulses 3×, `onionCount` 1, 2, 3, `potState = 2`. After 320 frames `potState = 1` and `cookProgress = 15`.
- **Debounce:** E held continuously → exactly one onion accepted. E released for 3 frames, then pressed → second onion accepted. E pressed after only 2 released frames → no action.
- **Pickup:** READY pot plus plate interact at frame 100 of READY → `potState = 0`, `onionCount = 0` on the same edge, `burnWarning` stays 0.
- **Burn:** READY held untouched → `burnWarning` rises at frame 240 and `potState = 3` at frame 480. A plate interact is then ignored; an empty-hand interact gives `potState = 0`.
- **Off-tile:** onion interact with `tileType = 1` or `wallFlag = 0` → no pulse and count unchanged.
- **Reset:** `Reset` asserted mid-COOKING (frame 150) → all outputs 0 immediately. After release, an onion interact is accepted from count 0.
